dram_resp: RTL and testbench

Data-memory responder at the far end of the execute-stage load/store interface. It consumes the registered `dram_as`/`dram_we`/`dram_addr`/funct3/`store_wdat` strobes, performs byte/half/word writes into an internal word-organised RAM, and returns aligned, sign- or zero-extended load data to write-back. An optional wait-state engine models slow memory and back-pressures the pipeline through `dram_busy`.

---
 rtl/dram_pkg.sv | 29 ++
 rtl/dram_load_align.sv | 38 +++
 rtl/dram_resp.sv | 212 +++++++++++++++++++++
 tb/tb_dram_resp.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/dram_pkg.sv
// Shared definitions for the data-memory responder: funct3 codes, FSM encoding and
// funct3 legality helpers.
package dram_pkg;

    localparam logic [2:0] F3_LB  = 3'd0;
    localparam logic [2:0] F3_LH  = 3'd1;
    localparam logic [2:0] F3_LW  = 3'd2;
    localparam logic [2:0] F3_LBU = 3'd4;
    localparam logic [2:0] F3_LHU = 3'd5;
    localparam logic [2:0] F3_SB  = 3'd0;
    localparam logic [2:0] F3_SH  = 3'd1;
    localparam logic [2:0] F3_SW  = 3'd2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dram_state_e;

    function automatic logic load_f3_legal(input logic [2:0] f3);
        return (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
               (f3 == F3_LBU) || (f3 == F3_LHU);
    endfunction

    function automatic logic store_f3_legal(input logic [2:0] f3);
        return (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
    endfunction

endpackage

// File: rtl/dram_load_align.sv
// Load lane select and sign/zero extension of a raw RAM word.
// Illegal funct3 codes produce zero.
module dram_load_align
    import dram_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [1:0]  i_off,
    input  logic [2:0]  i_funct3,
    output logic [31:0] o_dat
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = 8'd0;
        case (i_off)
            2'd0:    w_byte = i_word[7:0];
            2'd1:    w_byte = i_word[15:8];
            2'd2:    w_byte = i_word[23:16];
            default: w_byte = i_word[31:24];
        endcase
        w_half = i_off[1] ? i_word[31:16] : i_word[15:0];
    end

    always_comb begin
        o_dat = 32'd0;
        case (i_funct3)
            F3_LB:   o_dat = {{24{w_byte[7]}}, w_byte};
            F3_LH:   o_dat = {{16{w_half[15]}}, w_half};
            F3_LW:   o_dat = i_word;
            F3_LBU:  o_dat = {24'd0, w_byte};
            F3_LHU:  o_dat = {16'd0, w_half};
            default: o_dat = 32'd0;
        endcase
    end

endmodule

// File: rtl/dram_resp.sv
// Data-memory responder: byte/half/word stores into a word RAM, aligned extended loads.
// Define DRAM_WAIT_EN to build the wait-state FSM that back-pressures through dram_busy.
module dram_resp
    import dram_pkg::*;
#(
    parameter int ADDR_W   = 12,
    parameter int WAIT_CYC = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        dram_as,
    input  logic        dram_we,
    input  logic [31:0] dram_addr,
    input  logic [2:0]  i_type_load_funct3_wb,
    input  logic [2:0]  s_type_store_funct3_wb,
    input  logic [31:0] store_wdat,
    output logic [31:0] load_dat,
    output logic        load_val,
    output logic        dram_busy,
    output logic        access_fault
);

    localparam int DEPTH = 1 << ADDR_W;

    if (ADDR_W < 1 || ADDR_W > 29) begin : g_bad_addr_w
        $error("dram_resp: ADDR_W must be 1..29");
    end
    if (WAIT_CYC < 1 || WAIT_CYC > 15) begin : g_bad_wait_cyc
        $error("dram_resp: WAIT_CYC must be 1..15");
    end

    logic [31:0]       r_mem [DEPTH];

    logic              w_busy;
    logic              w_accept;
    logic              w_is_store;
    logic              w_is_load;
    logic              w_oor;
    logic              w_st_fault;
    logic              w_ld_fault;
    logic              w_wr_en;
    logic [ADDR_W-1:0] w_idx;
    logic [3:0]        w_be;
    logic [31:0]       w_wdat;

    // Response-start event and the request it answers (source differs per build)
    logic              w_rsp_evt;
    logic              w_rsp_load;
    logic              w_rsp_fault;
    logic [ADDR_W-1:0] w_rsp_idx;
    logic [1:0]        w_rsp_off;
    logic [2:0]        w_rsp_f3;

    logic [31:0]       r_word;
    logic [1:0]        r_off;
    logic [2:0]        r_f3;
    logic              r_load_val;
    logic              r_fault;

    assign w_accept   = !w_busy && (dram_as || dram_we);
    assign w_is_store = dram_we;
    assign w_is_load  = dram_as && !dram_we;
    assign w_oor      = |dram_addr[31:ADDR_W+2];
    assign w_idx      = dram_addr[ADDR_W+1:2];
    assign w_st_fault = w_oor || !store_f3_legal(s_type_store_funct3_wb);
    assign w_ld_fault = w_oor || !load_f3_legal(i_type_load_funct3_wb);
    assign w_wr_en    = w_accept && w_is_store && !w_st_fault;

    // Narrow stores replicate the data so every enabled lane sees the right bits
    always_comb begin
        w_be   = 4'b0000;
        w_wdat = store_wdat;
        case (s_type_store_funct3_wb)
            F3_SB: begin
                w_be   = 4'b0001 << dram_addr[1:0];
                w_wdat = {4{store_wdat[7:0]}};
            end
            F3_SH: begin
                w_be   = dram_addr[1] ? 4'b1100 : 4'b0011;
                w_wdat = {2{store_wdat[15:0]}};
            end
            F3_SW: begin
                w_be   = 4'b1111;
                w_wdat = store_wdat;
            end
            default: begin
                w_be   = 4'b0000;
                w_wdat = store_wdat;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) begin
                    r_mem[w_idx][8*b +: 8] <= w_wdat[8*b +: 8];
                end
            end
        end
    end

`ifdef DRAM_WAIT_EN
    localparam logic [3:0] CNT_INIT = 4'(WAIT_CYC - 1);

    dram_state_e       r_state;
    dram_state_e       w_state_nxt;
    logic [3:0]        r_cnt;
    logic [3:0]        w_cnt_nxt;
    logic [ADDR_W-1:0] r_req_idx;
    logic [1:0]        r_req_off;
    logic [2:0]        r_req_f3;
    logic              r_req_load;
    logic              r_req_fault;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            IDLE: begin
                if (dram_as || dram_we) begin
                    w_state_nxt = WAIT;
                    w_cnt_nxt   = CNT_INIT;
                end
            end
            WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_state_nxt = RESP;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            RESP:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_req_idx   <= '0;
            r_req_off   <= 2'd0;
            r_req_f3    <= F3_LW;
            r_req_load  <= 1'b0;
            r_req_fault <= 1'b0;
        end else if (w_accept) begin
            r_req_idx   <= w_idx;
            r_req_off   <= dram_addr[1:0];
            r_req_f3    <= i_type_load_funct3_wb;
            r_req_load  <= w_is_load;
            r_req_fault <= w_is_store ? w_st_fault : w_ld_fault;
        end
    end

    // RAM cannot change while busy, so reading at the end of WAIT sees the committed word
    assign w_busy      = (r_state != IDLE);
    assign w_rsp_evt   = (r_state == WAIT) && (r_cnt == 4'd0);
    assign w_rsp_load  = r_req_load;
    assign w_rsp_fault = r_req_fault;
    assign w_rsp_idx   = r_req_idx;
    assign w_rsp_off   = r_req_off;
    assign w_rsp_f3    = r_req_f3;
`else
    assign w_busy      = 1'b0;
    assign w_rsp_evt   = w_accept;
    assign w_rsp_load  = w_is_load;
    assign w_rsp_fault = w_is_store ? w_st_fault : w_ld_fault;
    assign w_rsp_idx   = w_idx;
    assign w_rsp_off   = dram_addr[1:0];
    assign w_rsp_f3    = i_type_load_funct3_wb;
`endif

    // Word/offset/funct3 only move on a load response, so load_dat holds in between
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_word     <= 32'd0;
            r_off      <= 2'd0;
            r_f3       <= F3_LW;
            r_load_val <= 1'b0;
            r_fault    <= 1'b0;
        end else begin
            r_load_val <= w_rsp_evt && w_rsp_load;
            r_fault    <= w_rsp_evt && w_rsp_fault;
            if (w_rsp_evt && w_rsp_load) begin
                r_word <= w_rsp_fault ? 32'd0 : r_mem[w_rsp_idx];
                r_off  <= w_rsp_off;
                r_f3   <= w_rsp_f3;
            end
        end
    end

    dram_load_align u_align (
        .i_word   (r_word),
        .i_off    (r_off),
        .i_funct3 (r_f3),
        .o_dat    (load_dat)
    );

    assign load_val     = r_load_val;
    assign access_fault = r_fault;
    assign dram_busy    = w_busy;

endmodule

// File: tb/tb_dram_resp.sv
// Scoreboard bench for dram_resp; works with or without DRAM_WAIT_EN defined.
module tb_dram_resp;
    import dram_pkg::*;

    localparam int ADDR_W   = 12;
    localparam int WAIT_CYC = 2;
`ifdef DRAM_WAIT_EN
    localparam int LAT      = 1 + WAIT_CYC;
    localparam int EXP_GAP  = WAIT_CYC + 2;
    localparam int EXP_BUSY = WAIT_CYC + 1;
`else
    localparam int LAT      = 1;
    localparam int EXP_GAP  = 1;
    localparam int EXP_BUSY = 0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        dram_as = 1'b0;
    logic        dram_we = 1'b0;
    logic [31:0] dram_addr = 32'd0;
    logic [2:0]  i_type_load_funct3_wb = 3'd0;
    logic [2:0]  s_type_store_funct3_wb = 3'd0;
    logic [31:0] store_wdat = 32'd0;
    logic [31:0] load_dat;
    logic        load_val;
    logic        dram_busy;
    logic        access_fault;

    dram_resp #(.ADDR_W(ADDR_W), .WAIT_CYC(WAIT_CYC)) dut (
        .clk                    (clk),
        .rst_n                  (rst_n),
        .dram_as                (dram_as),
        .dram_we                (dram_we),
        .dram_addr              (dram_addr),
        .i_type_load_funct3_wb  (i_type_load_funct3_wb),
        .s_type_store_funct3_wb (s_type_store_funct3_wb),
        .store_wdat             (store_wdat),
        .load_dat               (load_dat),
        .load_val               (load_val),
        .dram_busy              (dram_busy),
        .access_fault           (access_fault)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic        is_load;
        logic [31:0] dat;
        logic        fault;
        int          at;
        string       nm;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_vec = 0;
    int   n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h want 0x%08h", nm, act, exp);
        end
    endtask

    // Monitor: every presented response must match the oldest expectation
    always @(negedge clk) begin
        if (rst_n && (load_val || access_fault)) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_resp", {30'd0, load_val, access_fault}, 32'd0);
            end else begin
                mon_e = sb_q.pop_front();
                chk({mon_e.nm, ".load_val"}, {31'd0, load_val}, {31'd0, mon_e.is_load});
                if (mon_e.is_load) chk({mon_e.nm, ".load_dat"}, load_dat, mon_e.dat);
                chk({mon_e.nm, ".fault"}, {31'd0, access_fault}, {31'd0, mon_e.fault});
                chk({mon_e.nm, ".cycle"}, cyc, mon_e.at);
            end
        end
    end

    task automatic op(input logic as_i, input logic we_i, input logic [31:0] addr,
                      input logic [2:0] lf3, input logic [2:0] sf3, input logic [31:0] wdat,
                      output int acc_edge, output int busy_cnt);
        logic bz;
        dram_as = as_i;
        dram_we = we_i;
        dram_addr = addr;
        i_type_load_funct3_wb = lf3;
        s_type_store_funct3_wb = sf3;
        store_wdat = wdat;
        acc_edge = -1;
        busy_cnt = 0;
        for (int g = 0; g < 50; g++) begin
            bz = dram_busy;
            @(posedge clk);
            #1;
            if (!bz) begin
                acc_edge = cyc;
                break;
            end
            busy_cnt++;
        end
        dram_as = 1'b0;
        dram_we = 1'b0;
        if (acc_edge < 0) begin
            n_vec++;
            n_err++;
            $display("FAIL accept_timeout: request at 0x%08h never accepted", addr);
        end
    endtask

    task automatic st(input string nm, input logic [31:0] addr, input logic [2:0] sf3,
                      input logic [31:0] wdat, input logic exp_fault);
        int e, b;
        op(1'b0, 1'b1, addr, F3_LW, sf3, wdat, e, b);
        if (exp_fault) sb_q.push_back('{1'b0, 32'd0, 1'b1, e + LAT - 1, nm});
    endtask

    task automatic ld(input string nm, input logic [31:0] addr, input logic [2:0] lf3,
                      input logic [31:0] exp_dat, input logic exp_fault);
        int e, b;
        op(1'b1, 1'b0, addr, lf3, F3_SW, 32'd0, e, b);
        sb_q.push_back('{1'b1, exp_dat, exp_fault, e + LAT - 1, nm});
    endtask

    task automatic drain();
        for (int g = 0; g < 50 && sb_q.size() != 0; g++) @(posedge clk);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int e1, e2, b1, b2;

        repeat (3) @(posedge clk);
        #1;
        chk("rst.load_dat", load_dat, 32'd0);
        chk("rst.load_val", {31'd0, load_val}, 32'd0);
        chk("rst.busy", {31'd0, dram_busy}, 32'd0);
        chk("rst.fault", {31'd0, access_fault}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        st("sw10", 32'h10, F3_SW, 32'h8899AABB, 1'b0);
        ld("lw10_a", 32'h10, F3_LW, 32'h8899AABB, 1'b0);

        st("sb13", 32'h13, F3_SB, 32'h000000F0, 1'b0);
        ld("lb13", 32'h13, F3_LB, 32'hFFFFFFF0, 1'b0);
        ld("lbu13", 32'h13, F3_LBU, 32'h000000F0, 1'b0);
        ld("lw10_b", 32'h10, F3_LW, 32'hF099AABB, 1'b0);

        st("sh12", 32'h12, F3_SH, 32'h00001234, 1'b0);
        ld("lh12", 32'h12, F3_LH, 32'h00001234, 1'b0);
        ld("lhu10", 32'h10, F3_LHU, 32'h0000AABB, 1'b0);
        ld("lh10", 32'h10, F3_LH, 32'hFFFFAABB, 1'b0);
        ld("lb11", 32'h11, F3_LB, 32'hFFFFFFAA, 1'b0);
        ld("lbu10", 32'h10, F3_LBU, 32'h000000BB, 1'b0);

        st("sw00", 32'h0, F3_SW, 32'h11223344, 1'b0);
        ld("lw_oor", 32'h00010000, F3_LW, 32'h0, 1'b1);
        st("sw_oor", 32'h00010000, F3_SW, 32'hDEADBEEF, 1'b1);
        ld("lw00", 32'h0, F3_LW, 32'h11223344, 1'b0);
        ld("lw10_c", 32'h10, F3_LW, 32'h1234AABB, 1'b0);

        op(1'b1, 1'b1, 32'h30, F3_LW, F3_SW, 32'hCAFEF00D, e1, b1);
        ld("lw30", 32'h30, F3_LW, 32'hCAFEF00D, 1'b0);

        ld("ld_f3_3", 32'h10, 3'd3, 32'h0, 1'b1);
        ld("ld_f3_6", 32'h10, 3'd6, 32'h0, 1'b1);
        st("st_f3_3", 32'h10, 3'd3, 32'hFFFFFFFF, 1'b1);
        ld("lw10_d", 32'h10, F3_LW, 32'h1234AABB, 1'b0);
        drain();
        chk("hold.load_dat", load_dat, 32'h1234AABB);

        op(1'b1, 1'b0, 32'h0, F3_LW, F3_SW, 32'h0, e1, b1);
        sb_q.push_back('{1'b1, 32'h11223344, 1'b0, e1 + LAT - 1, "b2b_1"});
        op(1'b1, 1'b0, 32'h30, F3_LW, F3_SW, 32'h0, e2, b2);
        sb_q.push_back('{1'b1, 32'hCAFEF00D, 1'b0, e2 + LAT - 1, "b2b_2"});
        chk("b2b.gap", e2 - e1, EXP_GAP);
        chk("b2b.busy_cycles", b2, EXP_BUSY);
        drain();

        st("sw20", 32'h20, F3_SW, 32'h5A5A5A5A, 1'b0);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("midrst.busy", {31'd0, dram_busy}, 32'd0);
        chk("midrst.load_dat", load_dat, 32'd0);
        rst_n = 1'b1;
`ifdef DRAM_WAIT_EN
        @(posedge clk);
        #1;
        op(1'b1, 1'b0, 32'h10, F3_LW, F3_SW, 32'h0, e1, b1);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
`endif
        repeat (LAT + 2) @(posedge clk);
        #1;
        op(1'b1, 1'b0, 32'h20, F3_LW, F3_SW, 32'h0, e1, b1);
        sb_q.push_back('{1'b1, 32'h5A5A5A5A, 1'b0, e1 + LAT - 1, "lw20"});
        chk("post_rst.busy_cycles", b1, 32'd0);
        drain();

        chk("scoreboard.drain", sb_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
